// File: rtl/frame_bank_rotator.sv
// N-bank frame store that rotates bank ownership CAP -> FILT -> OUT -> free through in-order queues.
// Define FRAME_STATS_EN to enable the frame_count / drop_count registers; otherwise both outputs read 0.
module frame_bank_rotator #(
    parameter int unsigned frame_w     = 80,
    parameter int unsigned frame_h     = 160,
    parameter int unsigned disp_bits   = 5,
    parameter int unsigned bram_addr_w = 14,
    parameter int unsigned num_banks   = 3,
    parameter int unsigned rd_latency  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [8+disp_bits-1:0]    cd_wr_data,
    input  logic [bram_addr_w-1:0]    cd_wr_address,
    input  logic                      cd_wr_ena,
    input  logic [7:0]                gray_wr_data,
    input  logic [bram_addr_w-1:0]    gray_wr_address,
    input  logic                      gray_wr_ena,
    input  logic                      cap_done,
    input  logic [bram_addr_w-1:0]    filt_rd_address,
    output logic [16+disp_bits-1:0]   filt_rd_data,
    input  logic [16+disp_bits-1:0]   filt_wr_data,
    input  logic [bram_addr_w-1:0]    filt_wr_address,
    input  logic                      filt_wr_ena,
    output logic                      filt_valid,
    input  logic                      filt_done,
    input  logic [bram_addr_w-1:0]    out_rd_address,
    output logic [16+disp_bits-1:0]   out_rd_data,
    output logic                      out_valid,
    output logic                      out_new,
    input  logic                      out_done,
    output logic                      cap_overrun,
    output logic [15:0]               frame_count,
    output logic [15:0]               drop_count
);
    localparam int unsigned cd_w   = 8 + disp_bits;
    localparam int unsigned word_w = 16 + disp_bits;
    localparam int unsigned depth  = frame_w * frame_h;
    localparam int unsigned mem_aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned idx_w  = $clog2(num_banks);
    localparam int unsigned cnt_w  = $clog2(num_banks + 1);

    typedef enum logic [2:0] {
        BS_FREE, BS_CAP, BS_RDY_F, BS_FILT, BS_RDY_O, BS_OUT
    } bank_state_t;

    bank_state_t      bank_st   [num_banks];
    bank_state_t      bank_st_n [num_banks];
    logic [idx_w-1:0] fq        [num_banks];
    logic [idx_w-1:0] fq_n      [num_banks];
    logic [idx_w-1:0] oq        [num_banks];
    logic [idx_w-1:0] oq_n      [num_banks];
    logic [cnt_w-1:0] fq_cnt, fq_cnt_n, oq_cnt, oq_cnt_n;
    logic [idx_w-1:0] cap_idx, cap_idx_n, filt_idx, filt_idx_n, out_idx, out_idx_n;
    logic             filt_vld, filt_vld_n, out_vld, out_vld_n;
    logic             out_new_q, out_new_n, overrun_q, overrun_n;
    logic             alloc_found;
    logic [idx_w-1:0] alloc_idx;

    // Ownership update; events are applied in the order out_done, filt_done, cap_done.
    always_comb begin
        bank_st_n   = bank_st;
        fq_n        = fq;
        oq_n        = oq;
        fq_cnt_n    = fq_cnt;
        oq_cnt_n    = oq_cnt;
        cap_idx_n   = cap_idx;
        filt_idx_n  = filt_idx;
        filt_vld_n  = filt_vld;
        out_idx_n   = out_idx;
        out_vld_n   = out_vld;
        out_new_n   = 1'b0;
        overrun_n   = 1'b0;
        alloc_found = 1'b0;
        alloc_idx   = '0;

        if ((!out_vld || out_done) && oq_cnt != '0) begin
            if (out_vld) bank_st_n[out_idx] = BS_FREE;
            out_idx_n          = oq[0];
            out_vld_n          = 1'b1;
            out_new_n          = 1'b1;
            bank_st_n[oq[0]]   = BS_OUT;
            for (int i = 0; i < int'(num_banks) - 1; i++) oq_n[i] = oq[i+1];
            oq_n[num_banks-1]  = '0;
            oq_cnt_n           = oq_cnt - cnt_w'(1);
        end

        if (filt_vld && filt_done) begin
            bank_st_n[filt_idx]       = BS_RDY_O;
            oq_n[idx_w'(oq_cnt_n)]    = filt_idx;
            oq_cnt_n                  = oq_cnt_n + cnt_w'(1);
            filt_vld_n                = 1'b0;
        end else if (!filt_vld && fq_cnt != '0) begin
            filt_idx_n         = fq[0];
            filt_vld_n         = 1'b1;
            bank_st_n[fq[0]]   = BS_FILT;
            for (int i = 0; i < int'(num_banks) - 1; i++) fq_n[i] = fq[i+1];
            fq_n[num_banks-1]  = '0;
            fq_cnt_n           = fq_cnt - cnt_w'(1);
        end

        if (cap_done) begin
            for (int i = 0; i < int'(num_banks); i++) begin
                if (!alloc_found && bank_st_n[i] == BS_FREE) begin
                    alloc_found = 1'b1;
                    alloc_idx   = idx_w'(i);
                end
            end
            if (alloc_found) begin
                bank_st_n[cap_idx]      = BS_RDY_F;
                fq_n[idx_w'(fq_cnt_n)]  = cap_idx;
                fq_cnt_n                = fq_cnt_n + cnt_w'(1);
                bank_st_n[alloc_idx]    = BS_CAP;
                cap_idx_n               = alloc_idx;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(num_banks); i++) begin
                bank_st[i] <= (i == 0) ? BS_CAP : BS_FREE;
                fq[i]      <= '0;
                oq[i]      <= '0;
            end
            fq_cnt    <= '0;
            oq_cnt    <= '0;
            cap_idx   <= '0;
            filt_idx  <= '0;
            filt_vld  <= 1'b0;
            out_idx   <= '0;
            out_vld   <= 1'b0;
            out_new_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            bank_st   <= bank_st_n;
            fq        <= fq_n;
            oq        <= oq_n;
            fq_cnt    <= fq_cnt_n;
            oq_cnt    <= oq_cnt_n;
            cap_idx   <= cap_idx_n;
            filt_idx  <= filt_idx_n;
            filt_vld  <= filt_vld_n;
            out_idx   <= out_idx_n;
            out_vld   <= out_vld_n;
            out_new_q <= out_new_n;
            overrun_q <= overrun_n;
        end
    end

    assign filt_valid  = filt_vld;
    assign out_valid   = out_vld;
    assign out_new     = out_new_q;
    assign cap_overrun = overrun_q;

`ifdef FRAME_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (out_new_n) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (overrun_n) drop_cnt_q  <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

    logic [mem_aw-1:0] f_ra, o_ra;
    logic [word_w-1:0] f_bank [num_banks];
    logic [word_w-1:0] o_bank [num_banks];

    assign f_ra = mem_aw'(filt_rd_address);
    assign o_ra = mem_aw'(out_rd_address);

    // Each bank stores cd and gray halves separately so the two capture writers never collide.
    for (genvar b = 0; b < num_banks; b++) begin : g_bank
        logic [cd_w-1:0]   cd_mem   [depth];
        logic [7:0]        gray_mem [depth];
        logic              cd_we, gray_we;
        logic [mem_aw-1:0] cd_wa, gray_wa;
        logic [cd_w-1:0]   cd_wd;
        logic [7:0]        gray_wd;
        logic [word_w-1:0] f_pipe [rd_latency];
        logic [word_w-1:0] o_pipe [rd_latency];

        always_comb begin
            cd_we   = 1'b0;
            gray_we = 1'b0;
            cd_wa   = mem_aw'(cd_wr_address);
            gray_wa = mem_aw'(gray_wr_address);
            cd_wd   = cd_wr_data;
            gray_wd = gray_wr_data;
            if (cap_idx == idx_w'(b)) begin
                cd_we   = cd_wr_ena;
                gray_we = gray_wr_ena;
            end else if (filt_vld && filt_idx == idx_w'(b) && filt_wr_ena) begin
                cd_we   = 1'b1;
                gray_we = 1'b1;
                cd_wa   = mem_aw'(filt_wr_address);
                gray_wa = mem_aw'(filt_wr_address);
                cd_wd   = filt_wr_data[word_w-1:8];
                gray_wd = filt_wr_data[7:0];
            end
        end

        always_ff @(posedge clk) begin
            if (cd_we)   cd_mem[cd_wa]     <= cd_wd;
            if (gray_we) gray_mem[gray_wa] <= gray_wd;
            f_pipe[0] <= {cd_mem[f_ra], gray_mem[f_ra]};
            o_pipe[0] <= {cd_mem[o_ra], gray_mem[o_ra]};
            for (int s = 1; s < int'(rd_latency); s++) begin
                f_pipe[s] <= f_pipe[s-1];
                o_pipe[s] <= o_pipe[s-1];
            end
        end

        assign f_bank[b] = f_pipe[rd_latency-1];
        assign o_bank[b] = o_pipe[rd_latency-1];
    end

    // Role index/valid delayed to match read latency so in-flight reads follow the addressed bank.
    logic [idx_w-1:0] f_idx_d [rd_latency];
    logic [idx_w-1:0] o_idx_d [rd_latency];
    logic             f_vld_d [rd_latency];
    logic             o_vld_d [rd_latency];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(rd_latency); s++) begin
                f_idx_d[s] <= '0;
                o_idx_d[s] <= '0;
                f_vld_d[s] <= 1'b0;
                o_vld_d[s] <= 1'b0;
            end
        end else begin
            f_idx_d[0] <= filt_idx;
            o_idx_d[0] <= out_idx;
            f_vld_d[0] <= filt_vld;
            o_vld_d[0] <= out_vld;
            for (int s = 1; s < int'(rd_latency); s++) begin
                f_idx_d[s] <= f_idx_d[s-1];
                o_idx_d[s] <= o_idx_d[s-1];
                f_vld_d[s] <= f_vld_d[s-1];
                o_vld_d[s] <= o_vld_d[s-1];
            end
        end
    end

    assign filt_rd_data = f_vld_d[rd_latency-1] ? f_bank[f_idx_d[rd_latency-1]] : '0;
    assign out_rd_data  = o_vld_d[rd_latency-1] ? o_bank[o_idx_d[rd_latency-1]] : '0;
endmodule
